spi_reg_master: RTL and testbench

- SPI master that performs single-register writes and reads on a remote SPI register-file slave holding 2^A registers of D bits.
- A one-cycle WR or RD request on the system side is serialised into one SPI frame: 1 R/W bit, then A address bits, then D data bits, MSB first, SPI mode 0.
- Sits between a local controller and the off-chip/peer slave. BUSY covers the whole frame; DATAO returns read data.

---
 rtl/spi_reg_master.sv | 177 +++++++++++++++++
 tb/tb_spi_reg_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_master.sv
// spi_reg_master: serialises single-register write/read requests into one
// SPI frame {rw, ADDR, data}, MSB first, and returns read data on DATAO.
// Default build is SPI mode 0 (SCLK idles low).
// Optional macro SPI_MASTER_CPOL_EN: SCLK polarity inverted (idles high),
// with every phase length unchanged.
module spi_reg_master #(
    parameter int D       = 8,
    parameter int A       = 4,
    parameter int CLK_DIV = 1
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic [D-1:0] DATAI,
    input  logic [A-1:0] ADDR,
    input  logic         WR,
    input  logic         RD,
    output logic [D-1:0] DATAO,
    output logic         BUSY,
    output logic         SS,
    output logic         SCLK,
    output logic         MOSI,
    input  logic         MISO
);

    localparam int N  = 1 + A + D;
    localparam int CW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int BW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_lim;
    logic [BW-1:0]   bit_q;
    logic [N-1:0]    tx_q;
    logic [D-1:0]    rx_q;
    logic [D-1:0]    rx_shift;
    logic [D-1:0]    wr_data;
    logic [D-1:0]    datao_q;
    logic            rw_q;
    logic            accept;
    logic            enter_high;
    logic            enter_low;
    logic            finish;
    logic            phase_last;

    // HOLD spans the trailing SCLK-low half-period plus the select hold time,
    // which gives the full (2N+2)*CLK_DIV busy window.
    assign cnt_lim    = (state_q == S_HOLD) ? CW'(2 * CLK_DIV - 1) : CW'(CLK_DIV - 1);
    assign phase_last = (cnt_q == cnt_lim);
    assign wr_data    = WR ? DATAI : '0;

    // Next-state logic and phase strobes for the frame sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_high = 1'b0;
        enter_low  = 1'b0;
        finish     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (WR || RD) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end
            end
            S_SETUP: begin
                if (phase_last) begin
                    state_d    = S_HIGH;
                    cnt_d      = '0;
                    enter_high = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (phase_last) begin
                    cnt_d = '0;
                    if (bit_q == BW'(N)) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d   = S_LOW;
                        enter_low = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOW: begin
                if (phase_last) begin
                    state_d    = S_HIGH;
                    cnt_d      = '0;
                    enter_high = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (phase_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, phase counter and bit counter registers
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                bit_q <= '0;
            end else if (enter_high) begin
                bit_q <= bit_q + 1'b1;
            end
        end
    end

    // Receive shift: the new MISO bit enters at the LSB
    always_comb begin
        rx_shift    = rx_q << 1;
        rx_shift[0] = MISO;
    end

    // Frame shift registers: load on accept, shift MOSI on falling SCLK, sample MISO on rising SCLK
    always_ff @(posedge CLOCK) begin
        if (accept) begin
            tx_q <= {~WR, ADDR, wr_data};
            rw_q <= ~WR;
        end else if (enter_low) begin
            tx_q <= tx_q << 1;
        end
        if (enter_high) begin
            rx_q <= rx_shift;
        end
    end

    // Read data register, updated only when a read frame completes
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            datao_q <= '0;
        end else if (finish && rw_q) begin
            datao_q <= rx_q;
        end
    end

    assign DATAO = datao_q;
    assign BUSY  = (state_q != S_IDLE);
    assign SS    = (state_q == S_IDLE);
    assign MOSI  = (state_q != S_IDLE) && tx_q[N-1];
`ifdef SPI_MASTER_CPOL_EN
    assign SCLK  = (state_q != S_HIGH);
`else
    assign SCLK  = (state_q == S_HIGH);
`endif

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master (default mode 0 build) with a small
// register-file slave model attached to the SPI pins.
module tb_spi_reg_master;

    localparam int D = 8;
    localparam int A = 4;
    localparam int N = 1 + A + D;

    logic         CLOCK = 1'b0;
    logic         RESET;
    logic [D-1:0] DATAI;
    logic [A-1:0] ADDR;
    logic         WR;
    logic         RD;
    logic [D-1:0] DATAO;
    logic         BUSY;
    logic         SS;
    logic         SCLK;
    logic         MOSI;
    logic         MISO;

    int nvec = 0;
    int nmis = 0;

    spi_reg_master #(.D(D), .A(A), .CLK_DIV(1)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .DATAI (DATAI),
        .ADDR  (ADDR),
        .WR    (WR),
        .RD    (RD),
        .DATAO (DATAO),
        .BUSY  (BUSY),
        .SS    (SS),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    always #5 CLOCK = ~CLOCK;

    // ---------------- slave register file model ----------------
    logic [D-1:0] mem [1<<A];
    logic [N-1:0] sh;
    logic [N-1:0] last_frame;
    logic [A-1:0] rd_addr;
    int           bcnt;
    int           rise_total;
    int           frames;

    initial begin
        for (int i = 0; i < (1 << A); i++) mem[i] = '0;
        sh = '0; last_frame = '0; rd_addr = '0;
        bcnt = 0; rise_total = 0; frames = 0;
        MISO = 1'b0;
    end

    always @(negedge SS) begin
        bcnt = 0;
        sh   = '0;
    end

    always @(posedge SCLK) begin
        if (SS == 1'b0) begin
            sh = {sh[N-2:0], MOSI};
            bcnt++;
            rise_total++;
            if (bcnt == 1 + A) rd_addr = sh[A-1:0];
            if (bcnt == N) begin
                last_frame = sh;
                frames++;
                if (sh[N-1] == 1'b0) mem[sh[D+A-1:D]] = sh[D-1:0];
            end
        end
    end

    always @(negedge SCLK) begin
        if (SS == 1'b0 && bcnt >= 1 + A && bcnt < N)
            MISO = mem[rd_addr][D-1-(bcnt-1-A)];
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request pulse, then count the cycles BUSY stays high (bounded)
    task automatic do_frame(input logic wr, input logic rd, input logic [A-1:0] a,
                            input logic [D-1:0] d, output int busy_cycles);
        ADDR = a; DATAI = d; WR = wr; RD = rd;
        @(posedge CLOCK); #1;
        WR = 1'b0; RD = 1'b0;
        busy_cycles = 0;
        while (BUSY && busy_cycles < 200) begin
            busy_cycles++;
            @(posedge CLOCK); #1;
        end
        @(posedge CLOCK); #1;
    endtask

    int bc;
    int r0;
    int f0;

    initial begin
        RESET = 1'b1; WR = 1'b0; RD = 1'b0; ADDR = '0; DATAI = '0;
        repeat (3) @(posedge CLOCK);
        #1;
        check("rst_ss",    32'(SS),    32'h1);
        check("rst_sclk",  32'(SCLK),  32'h0);
        check("rst_mosi",  32'(MOSI),  32'h0);
        check("rst_busy",  32'(BUSY),  32'h0);
        check("rst_datao", 32'(DATAO), 32'h0);
        RESET = 1'b0;
        @(posedge CLOCK); #1;

        // write reg 15 = 15
        r0 = rise_total;
        do_frame(1'b1, 1'b0, 4'd15, 8'd15, bc);
        check("wr15_busy",  32'(bc), 32'd28);
        check("wr15_rises", 32'(rise_total - r0), 32'd13);
        check("wr15_mosi",  32'(last_frame), 32'(13'b0_1111_00001111));
        check("wr15_mem",   32'(mem[15]), 32'd15);

        // writes (0,6), (7,205)
        do_frame(1'b1, 1'b0, 4'd0, 8'd6, bc);
        do_frame(1'b1, 1'b0, 4'd7, 8'd205, bc);
        check("wr0_mem", 32'(mem[0]), 32'd6);
        check("wr7_mem", 32'(mem[7]), 32'd205);

        // reads
        r0 = rise_total;
        do_frame(1'b0, 1'b1, 4'd7, 8'h5C, bc);
        check("rd7_busy",  32'(bc), 32'd28);
        check("rd7_rises", 32'(rise_total - r0), 32'd13);
        check("rd7_mosi",  32'(last_frame), 32'(13'b1_0111_00000000));
        check("rd7_datao", 32'(DATAO), 32'd205);
        do_frame(1'b0, 1'b1, 4'd0, 8'h00, bc);
        check("rd0_datao", 32'(DATAO), 32'd6);
        do_frame(1'b0, 1'b1, 4'd15, 8'h00, bc);
        check("rd15_datao", 32'(DATAO), 32'd15);

        // WR pulsed mid-frame is ignored
        f0 = frames;
        ADDR = 4'd1; DATAI = 8'h22; WR = 1'b1;
        @(posedge CLOCK); #1;
        WR = 1'b0;
        repeat (4) @(posedge CLOCK);
        #1;
        ADDR = 4'd3; DATAI = 8'd9; WR = 1'b1;
        @(posedge CLOCK); #1;
        WR = 1'b0;
        repeat (60) @(posedge CLOCK);
        #1;
        check("ign_frames", 32'(frames - f0), 32'd1);
        check("ign_mem3",   32'(mem[3]), 32'd0);
        check("ign_mem1",   32'(mem[1]), 32'h22);
        check("ign_busy",   32'(BUSY), 32'h0);

        // WR and RD together: write wins, DATAO held
        do_frame(1'b1, 1'b1, 4'd2, 8'hAA, bc);
        check("both_mosi",  32'(last_frame), 32'(13'b0_0010_10101010));
        check("both_mem2",  32'(mem[2]), 32'hAA);
        check("both_datao", 32'(DATAO), 32'd15);

        // reset at cycle 10 of a write aborts it
        ADDR = 4'd4; DATAI = 8'h5A; WR = 1'b1;
        @(posedge CLOCK); #1;
        WR = 1'b0;
        repeat (9) @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        @(posedge CLOCK); #1;
        r0 = rise_total;
        check("abort_ss",    32'(SS),    32'h1);
        check("abort_sclk",  32'(SCLK),  32'h0);
        check("abort_busy",  32'(BUSY),  32'h0);
        check("abort_mosi",  32'(MOSI),  32'h0);
        check("abort_datao", 32'(DATAO), 32'h0);
        RESET = 1'b0;
        repeat (40) @(posedge CLOCK);
        #1;
        check("abort_rises", 32'(rise_total - r0), 32'd0);
        check("abort_mem4",  32'(mem[4]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
